// File: rtl/ob_tracker_if.sv
// ob_tracker_if: lookup, result, flush and close-handshake bundle between the
// request queue / command sequencer side (master) and the bank tracker (slave).
interface ob_tracker_if #(
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned RANK_W = 1
);
    localparam int unsigned CntW = BANK_W + RANK_W + 1;

    logic              lkValid;
    logic              lkReady;
    logic [ROW_W-1:0]  lkRow;
    logic [BANK_W-1:0] lkBank;
    logic [RANK_W-1:0] lkRank;

    logic              resValid;
    logic [2:0]        resKind;
    logic [BANK_W-1:0] resBank;
    logic [RANK_W-1:0] resRank;

    logic              redoValid;
    logic              flushAll;
    logic              flushRank;
    logic [RANK_W-1:0] flushRankId;

    logic              closeReq;
    logic [BANK_W-1:0] closeBank;
    logic [RANK_W-1:0] closeRank;
    logic              closeAck;

    logic [CntW-1:0]   openCount;

    modport master (
        output lkValid, lkRow, lkBank, lkRank, redoValid, flushAll, flushRank,
               flushRankId, closeAck,
        input  lkReady, resValid, resKind, resBank, resRank, closeReq, closeBank,
               closeRank, openCount
    );

    modport slave (
        input  lkValid, lkRow, lkBank, lkRank, redoValid, flushAll, flushRank,
               flushRankId, closeAck,
        output lkReady, resValid, resKind, resBank, resRank, closeReq, closeBank,
               closeRank, openCount
    );
endinterface

// File: rtl/ob_tracker.sv
// ob_tracker: open-bank/open-row table for 2^RANK_W ranks x 2^BANK_W banks.
// Classifies lookups as hit / no-conflict miss / conflict, requests precharge
// of banks left idle for IDLE_CYCLES, supports per-rank refresh flush and
// reports the number of open banks.
module ob_tracker #(
    parameter int unsigned ROW_W       = 14,
    parameter int unsigned BANK_W      = 3,
    parameter int unsigned RANK_W      = 1,
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned TMR_W       = 7
) (
    input logic         CLK,
    input logic         Reset_n,
    ob_tracker_if.slave bus
);
    localparam int unsigned IdxW = BANK_W + RANK_W;
    localparam int unsigned Nb   = 1 << IdxW;
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [TMR_W-1:0] IdleMax = TMR_W'(IDLE_CYCLES);

    localparam logic [2:0] KindHit  = 3'b001;
    localparam logic [2:0] KindMiss = 3'b010;
    localparam logic [2:0] KindConf = 3'b100;

    typedef enum logic [0:0] {StIdle, StReq} close_st_e;

    logic [Nb-1:0]              valid_q, valid_d;
    logic [Nb-1:0][TMR_W-1:0]   timer_q, timer_d;
    logic [ROW_W-1:0]           row_q [Nb];

    logic                       res_valid_q, res_valid_d;
    logic [2:0]                 res_kind_q, res_kind_d;
    logic [BANK_W-1:0]          res_bank_q, res_bank_d;
    logic [RANK_W-1:0]          res_rank_q, res_rank_d;

    close_st_e                  state_q, state_d;
    logic [IdxW-1:0]            close_idx_q, close_idx_d;
    logic                       close_req_q, close_req_d;
    logic [CntW-1:0]            open_cnt_q, open_cnt_d;

    logic                       lk_ready;
    logic                       accept;
    logic [IdxW-1:0]            lk_idx;
    logic [IdxW-1:0]            res_idx;
    logic                       ack_take;
    logic [Nb-1:0]              kill;
    logic [Nb-1:0]              elig;
    logic [IdxW-1:0]            pick;

    assign lk_ready = ~(bus.flushAll | bus.flushRank | bus.closeAck);
    assign accept   = bus.lkValid & lk_ready;
    assign lk_idx   = {bus.lkRank, bus.lkBank};
    assign res_idx  = {res_rank_q, res_bank_q};
    // A close acknowledge only means something while a request is outstanding.
    assign ack_take = bus.closeAck & (state_q == StReq);

    // Per-bank invalidation this cycle: global flush, rank flush or acked close.
    always_comb begin
        kill = '0;
        for (int i = 0; i < Nb; i++) begin
            kill[i] = bus.flushAll
                    | (bus.flushRank & (RANK_W'(i >> BANK_W) == bus.flushRankId))
                    | (ack_take & (close_idx_q == IdxW'(i)));
        end
    end

    // Valid bits, idle timers and the registered open-bank population count.
    always_comb begin
        valid_d    = valid_q;
        timer_d    = timer_q;
        open_cnt_d = '0;
        for (int i = 0; i < Nb; i++) begin
            if (kill[i]) begin
                valid_d[i] = 1'b0;
                timer_d[i] = '0;
            end else if (accept && (lk_idx == IdxW'(i))) begin
                valid_d[i] = 1'b1;
                timer_d[i] = '0;
            end else begin
                // Aborted precharge: reopen the bank of the last result.
                if (bus.redoValid && (res_idx == IdxW'(i))) begin
                    valid_d[i] = 1'b1;
                end
                if (valid_q[i] && (timer_q[i] < IdleMax)) begin
                    timer_d[i] = timer_q[i] + TMR_W'(1);
                end
            end
            open_cnt_d = open_cnt_d + CntW'(valid_d[i]);
        end
    end

    // Eligible banks exclude any bank being touched this cycle; pick lowest index.
    always_comb begin
        elig = '0;
        pick = '0;
        for (int i = 0; i < Nb; i++) begin
            elig[i] = (IDLE_CYCLES != 0) && valid_q[i] && (timer_q[i] == IdleMax)
                   && !kill[i] && !(accept && (lk_idx == IdxW'(i)));
        end
        for (int i = Nb - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick = IdxW'(i);
            end
        end
    end

    // Close-request FSM next state; closeReq is registered from the next state.
    always_comb begin
        state_d     = state_q;
        close_idx_d = close_idx_q;
        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d     = StReq;
                    close_idx_d = pick;
                end
            end
            StReq: begin
                // Ack, flush or a fresh access to the latched bank ends the request.
                if (kill[close_idx_q] || (accept && (lk_idx == close_idx_q))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        close_req_d = (state_d == StReq);
    end

    // Lookup result, classified against the table before this cycle's update.
    always_comb begin
        res_valid_d = accept;
        res_kind_d  = res_kind_q;
        res_bank_d  = res_bank_q;
        res_rank_d  = res_rank_q;
        if (accept) begin
            res_bank_d = bus.lkBank;
            res_rank_d = bus.lkRank;
            if (!valid_q[lk_idx]) begin
                res_kind_d = KindMiss;
            end else if (row_q[lk_idx] == bus.lkRow) begin
                res_kind_d = KindHit;
            end else begin
                res_kind_d = KindConf;
            end
        end else if (bus.flushAll || (bus.flushRank && (bus.flushRankId == res_rank_q))) begin
            res_kind_d = KindMiss;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q     <= '0;
            timer_q     <= '0;
            res_valid_q <= 1'b0;
            res_kind_q  <= KindMiss;
            res_bank_q  <= '0;
            res_rank_q  <= '0;
            state_q     <= StIdle;
            close_idx_q <= '0;
            close_req_q <= 1'b0;
            open_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            timer_q     <= timer_d;
            res_valid_q <= res_valid_d;
            res_kind_q  <= res_kind_d;
            res_bank_q  <= res_bank_d;
            res_rank_q  <= res_rank_d;
            state_q     <= state_d;
            close_idx_q <= close_idx_d;
            close_req_q <= close_req_d;
            open_cnt_q  <= open_cnt_d;
        end
    end

    // Row storage is don't-care while invalid, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            row_q[lk_idx] <= bus.lkRow;
        end
    end

    assign bus.lkReady   = lk_ready;
    assign bus.resValid  = res_valid_q;
    assign bus.resKind   = res_kind_q;
    assign bus.resBank   = res_bank_q;
    assign bus.resRank   = res_rank_q;
    assign bus.closeReq  = close_req_q;
    assign bus.closeBank = close_idx_q[BANK_W-1:0];
    assign bus.closeRank = close_idx_q[IdxW-1:BANK_W];
    assign bus.openCount = open_cnt_q;
endmodule

// File: tb/tb_ob_tracker.sv
// tb_ob_tracker: directed vectors with hand-computed expectations for ob_tracker
// built with a short idle threshold (IDLE_CYCLES=4).
module tb_ob_tracker;
    localparam int unsigned ROW_W  = 14;
    localparam int unsigned BANK_W = 3;
    localparam int unsigned RANK_W = 1;
    localparam int unsigned IDLE   = 4;
    localparam int unsigned TMR_W  = 3;

    localparam int KHit  = 1;
    localparam int KMiss = 2;
    localparam int KConf = 4;

    logic CLK = 1'b0;
    logic Reset_n;

    always #5 CLK = ~CLK;

    ob_tracker_if #(.ROW_W(ROW_W), .BANK_W(BANK_W), .RANK_W(RANK_W)) bus ();

    ob_tracker #(
        .ROW_W      (ROW_W),
        .BANK_W     (BANK_W),
        .RANK_W     (RANK_W),
        .IDLE_CYCLES(IDLE),
        .TMR_W      (TMR_W)
    ) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lkValid     = 1'b0;
        bus.lkRow       = '0;
        bus.lkBank      = '0;
        bus.lkRank      = '0;
        bus.redoValid   = 1'b0;
        bus.flushAll    = 1'b0;
        bus.flushRank   = 1'b0;
        bus.flushRankId = '0;
        bus.closeAck    = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        Reset_n = 1'b1;
    endtask

    task automatic lookup(input logic [RANK_W-1:0] rk, input logic [BANK_W-1:0] bk,
                          input logic [ROW_W-1:0] row);
        bus.lkValid = 1'b1;
        bus.lkRank  = rk;
        bus.lkBank  = bk;
        bus.lkRow   = row;
        step();
        bus.lkValid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int kind);
        check({tag, "_valid"}, 32'(bus.resValid), 1);
        check({tag, "_kind"}, 32'(bus.resKind), kind);
    endtask

    // Bounded wait for closeReq; an expired bound shows up as a failed check.
    task automatic wait_close(input string tag, input int maxc);
        for (int c = 0; c < maxc && bus.closeReq !== 1'b1; c++) step();
        check(tag, 32'(bus.closeReq), 1);
    endtask

    task automatic ack_close();
        bus.closeAck = 1'b1;
        #1;
        check("ack_lkready", 32'(bus.lkReady), 0);
        step();
        bus.closeAck = 1'b0;
    endtask

    // closeReq must stay low for n cycles and then rise on the next.
    task automatic expect_req_after(input string tag, input int n);
        int early = 0;
        for (int c = 0; c < n; c++) begin
            step();
            if (bus.closeReq !== 1'b0) early++;
        end
        check({tag, "_early"}, 32'(early), 0);
        step();
        check({tag, "_rise"}, 32'(bus.closeReq), 1);
    endtask

    initial begin
        Reset_n = 1'b0;
        idle_inputs();
        step();
        step();

        // Reset state
        check("rst_resvalid", 32'(bus.resValid), 0);
        check("rst_reskind", 32'(bus.resKind), KMiss);
        check("rst_resbank", 32'(bus.resBank), 0);
        check("rst_closereq", 32'(bus.closeReq), 0);
        check("rst_opencount", 32'(bus.openCount), 0);
        check("rst_lkready", 32'(bus.lkReady), 1);
        Reset_n = 1'b1;

        // Basic classification on rank 0 bank 3
        lookup(0, 3, 14'h1A2B);
        chk_res("t1_miss", KMiss);
        check("t1_bank", 32'(bus.resBank), 3);
        check("t1_rank", 32'(bus.resRank), 0);
        check("t1_open", 32'(bus.openCount), 1);
        lookup(0, 3, 14'h1A2B);
        chk_res("t1_hit", KHit);
        lookup(0, 3, 14'h1A2C);
        chk_res("t1_conf", KConf);
        lookup(0, 3, 14'h1A2C);
        chk_res("t1_rowupd", KHit);
        step();
        check("t1_pulse", 32'(bus.resValid), 0);
        check("t1_hold", 32'(bus.resKind), KHit);

        // Fill all 16 banks, rank flush, then flushAll against a lookup
        do_reset();
        for (int i = 0; i < 16; i++) begin
            lookup(RANK_W'(i >> 3), BANK_W'(i), ROW_W'(32'h100 + i));
        end
        check("t2_full", 32'(bus.openCount), 16);
        lookup(1, 7, 14'h10F);
        chk_res("t2_hit15", KHit);
        bus.flushRank   = 1'b1;
        bus.flushRankId = 1'b1;
        #1;
        check("t2_fr_lkready", 32'(bus.lkReady), 0);
        step();
        bus.flushRank = 1'b0;
        check("t2_fr_open", 32'(bus.openCount), 8);
        check("t2_fr_kind", 32'(bus.resKind), KMiss);
        lookup(1, 2, 14'h10A);
        chk_res("t2_r1_miss", KMiss);
        lookup(0, 2, 14'h102);
        chk_res("t2_r0_hit", KHit);
        check("t2_open9", 32'(bus.openCount), 9);
        bus.flushAll = 1'b1;
        bus.lkValid  = 1'b1;
        bus.lkRank   = 0;
        bus.lkBank   = 2;
        bus.lkRow    = 14'h102;
        #1;
        check("t2_fa_lkready", 32'(bus.lkReady), 0);
        step();
        bus.flushAll = 1'b0;
        bus.lkValid  = 1'b0;
        check("t2_fa_noresult", 32'(bus.resValid), 0);
        check("t2_fa_open", 32'(bus.openCount), 0);
        lookup(0, 2, 14'h102);
        chk_res("t2_fa_miss", KMiss);

        // Idle close of bank 5
        do_reset();
        lookup(0, 5, 14'h0555);
        chk_res("t3_miss", KMiss);
        expect_req_after("t3_req", 4);
        check("t3_bank", 32'(bus.closeBank), 5);
        check("t3_rank", 32'(bus.closeRank), 0);
        begin
            int unstable = 0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (bus.closeReq !== 1'b1 || bus.closeBank !== 3'd5 || bus.closeRank !== 1'b0)
                    unstable++;
            end
            check("t3_stable", 32'(unstable), 0);
        end
        ack_close();
        check("t3_ack_req", 32'(bus.closeReq), 0);
        check("t3_ack_open", 32'(bus.openCount), 0);
        step();
        check("t3_ack_req2", 32'(bus.closeReq), 0);
        lookup(0, 5, 14'h0555);
        chk_res("t3_closed_miss", KMiss);

        // Banks 2 and 6 eligible together while bank 1 is being closed
        do_reset();
        lookup(0, 1, 14'h0011);
        lookup(0, 6, 14'h0066);
        lookup(0, 2, 14'h0022);
        wait_close("t4_req1", 20);
        check("t4_bank1", 32'(bus.closeBank), 1);
        step();
        step();
        step();
        ack_close();
        check("t4_gap", 32'(bus.closeReq), 0);
        check("t4_open2", 32'(bus.openCount), 2);
        step();
        check("t4_req2", 32'(bus.closeReq), 1);
        check("t4_bank2", 32'(bus.closeBank), 2);
        ack_close();
        check("t4_gap2", 32'(bus.closeReq), 0);
        check("t4_open1", 32'(bus.openCount), 1);
        wait_close("t4_req6", 5);
        check("t4_bank6", 32'(bus.closeBank), 6);

        // Pending close withdrawn by a lookup to the same bank
        do_reset();
        lookup(0, 2, 14'h0055);
        wait_close("t5_req", 12);
        check("t5_bank", 32'(bus.closeBank), 2);
        lookup(0, 2, 14'h0055);
        check("t5_withdraw", 32'(bus.closeReq), 0);
        chk_res("t5_hit", KHit);
        expect_req_after("t5_restart", 4);

        // Conflict, close ack, redo, then reset mid-request
        do_reset();
        lookup(0, 4, 14'h0010);
        chk_res("t6_miss", KMiss);
        lookup(0, 4, 14'h0020);
        chk_res("t6_conf", KConf);
        wait_close("t6_req", 12);
        check("t6_bank", 32'(bus.closeBank), 4);
        ack_close();
        check("t6_ack_open", 32'(bus.openCount), 0);
        bus.redoValid = 1'b1;
        step();
        bus.redoValid = 1'b0;
        check("t6_redo_open", 32'(bus.openCount), 1);
        lookup(0, 4, 14'h0020);
        chk_res("t6_redo_hit", KHit);
        wait_close("t6_req2", 12);
        Reset_n = 1'b0;
        #1;
        check("t6_async_req", 32'(bus.closeReq), 0);
        check("t6_async_open", 32'(bus.openCount), 0);
        check("t6_async_kind", 32'(bus.resKind), KMiss);
        step();
        Reset_n = 1'b1;
        lookup(0, 4, 14'h0020);
        chk_res("t6_post_miss4", KMiss);
        lookup(1, 0, 14'h0000);
        chk_res("t6_post_miss8", KMiss);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
